// File: rtl/bcd_ctrl_pkg.sv
// Shared widths, timing limits and controller state type for the BCD converter arbiter.
package bcd_ctrl_pkg;

  localparam int BIN_W           = 16;
  localparam int BCD_DIGITS      = 5;
  localparam int BCD_W           = 4 * BCD_DIGITS;
  localparam int CONV_CYCLES_MIN = 183;
  localparam int CNT_W           = 8;

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sharing of one multi-cycle binary-to-BCD converter between N_REQ requesters.
// Optional single-entry result cache enabled by defining BCD_CACHE_EN.
module bcd_conv_arbiter
  import bcd_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CONV_CYCLES = 184
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [BIN_W*N_REQ-1:0] bin_bus,
  output logic [N_REQ-1:0]       ack,
  output logic [BCD_W-1:0]       bcd_out,
  output logic                   busy,
  output logic                   conv_start,
  output logic [BIN_W-1:0]       conv_bin,
  input  logic [BCD_W-1:0]       conv_bcd
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr, win_idx, pick_idx;
  logic [N_REQ-1:0]   win_grant, pick_grant;
  logic [BIN_W-1:0]   operand, pick_operand;
  logic [BIN_W-1:0]   ops [N_REQ];
  logic               hit;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      ops[i] = bin_bus[BIN_W*i +: BIN_W];
    end
  end

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

  assign pick_operand = ops[pick_idx];

`ifdef BCD_CACHE_EN
  logic               cache_valid;
  logic [BIN_W-1:0]   cache_bin;
  logic [BCD_W-1:0]   cache_bcd;
  assign hit = cache_valid && (cache_bin == pick_operand);
`else
  assign hit = 1'b0;
`endif

  assign busy       = (state != S_IDLE);
  assign conv_start = (state == S_START);
  assign conv_bin   = operand;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FLUSH: if (cnt == '0) state_nxt = S_IDLE;
      S_IDLE:  if (|req) state_nxt = hit ? S_DONE : S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_FLUSH;
    endcase
  end

  // ack/bcd_out are loaded on the edge entering S_DONE so they are valid during S_DONE itself
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FLUSH;
      cnt       <= CNT_W'(CONV_CYCLES);
      ptr       <= '0;
      win_idx   <= '0;
      win_grant <= '0;
      operand   <= '0;
      ack       <= '0;
      bcd_out   <= '0;
`ifdef BCD_CACHE_EN
      cache_valid <= 1'b0;
      cache_bin   <= '0;
      cache_bcd   <= '0;
`endif
    end else begin
      state <= state_nxt;
      ack   <= '0;
      case (state)
        S_FLUSH: if (cnt != '0) cnt <= cnt - 1'b1;
        S_IDLE: begin
          if (|req) begin
            win_idx   <= pick_idx;
            win_grant <= pick_grant;
            operand   <= pick_operand;
`ifdef BCD_CACHE_EN
            if (hit) begin
              ack     <= pick_grant;
              bcd_out <= cache_bcd;
            end
`endif
          end
        end
        S_START: cnt <= CNT_W'(CONV_CYCLES - 1);
        S_WAIT: begin
          if (cnt == '0) begin
            ack     <= win_grant;
            bcd_out <= conv_bcd;
`ifdef BCD_CACHE_EN
            cache_valid <= 1'b1;
            cache_bin   <= operand;
            cache_bcd   <= conv_bcd;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: ptr <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter with a behavioural converter and arbitration model.
module tb_bcd_conv_arbiter;

  localparam int N = 4;
  localparam int C = 184;
`ifdef BCD_CACHE_EN
  localparam bit USE_CACHE = 1'b1;
`else
  localparam bit USE_CACHE = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [16*N-1:0] bin_bus = '0;
  logic [N-1:0]  ack;
  logic [19:0]   bcd_out;
  logic          busy;
  logic          conv_start;
  logic [15:0]   conv_bin;
  logic [19:0]   conv_bcd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          ptr_m = 0;
  bit          cache_v = 1'b0;
  logic [15:0] cache_op = '0;

  typedef struct {
    int          idx;
    logic [15:0] op;
    logic [19:0] exp;
  } vec_t;
  vec_t tbl [5];

  bcd_conv_arbiter #(
    .N_REQ(N),
    .CONV_CYCLES(C)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .bin_bus   (bin_bus),
    .ack       (ack),
    .bcd_out   (bcd_out),
    .busy      (busy),
    .conv_start(conv_start),
    .conv_bin  (conv_bin),
    .conv_bcd  (conv_bcd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [19:0] bcd_ref(input logic [15:0] v);
    logic [19:0] r;
    int x;
    x = int'(v);
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter with no reset: result becomes final C edges after the start edge, garbage before.
  logic [15:0] cv_op = '0;
  int          cv_left = C;
  always @(posedge clock) begin
    if (conv_start) begin
      cv_op   <= conv_bin;
      cv_left <= C - 1;
    end else if (cv_left > 0) begin
      cv_left <= cv_left - 1;
    end
  end
  assign conv_bcd = (cv_left == 0) ? bcd_ref(cv_op) : 20'hEEEEE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  logic prev_ack = 1'b0;
  always @(negedge clock) begin
    if (reset_n && ack != '0) begin
      check("ack_onehot", 64'($onehot(ack)), 64'd1);
      check("ack_one_cycle", 64'(prev_ack), 64'd0);
    end
    prev_ack = (ack != '0);
  end

  function automatic int model_pick(input logic [N-1:0] pend);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  // Called at the negedge of cycle r0, the first idle cycle in which the mask is requesting.
  task automatic serve(input logic [N-1:0] mask, input int r0);
    logic [N-1:0] pend;
    logic [15:0]  op;
    int r, w, exp_ack, exp_start;
    bit hit, started, got;
    pend = mask;
    r = r0;
    while (pend != '0) begin
      w = model_pick(pend);
      op = bin_bus[16*w +: 16];
      hit = USE_CACHE && cache_v && (cache_op == op);
      exp_ack = hit ? r + 1 : r + C + 2;
      exp_start = hit ? -1 : r + 1;
      started = 1'b0;
      got = 1'b0;
      while (!got && cyc <= exp_ack + 4) begin
        @(negedge clock);
        if (conv_start) begin
          check("start_cycle", 64'(cyc), 64'(exp_start));
          started = 1'b1;
        end
        if (ack != '0) begin
          got = 1'b1;
          check("ack_idx", 64'(ack), 64'(1 << w));
          check("ack_cycle", 64'(cyc), 64'(exp_ack));
          check("bcd_out", 64'(bcd_out), 64'(bcd_ref(op)));
          check("busy_in_done", 64'(busy), 64'd1);
        end
      end
      if (!got) check("ack_timeout", 64'd0, 64'd1);
      if (!hit && !started) check("start_missing", 64'd0, 64'd1);
      req[w] = 1'b0;
      pend[w] = 1'b0;
      ptr_m = (w + 1) % N;
      if (USE_CACHE && !hit) begin
        cache_v = 1'b1;
        cache_op = op;
      end
      r = cyc + 1;
    end
    @(negedge clock);
    check("busy_fall", 64'(busy), 64'd0);
    check("ack_clear", 64'(ack), 64'd0);
  endtask

  // Leaves the caller at the negedge of the first idle cycle after the flush.
  task automatic do_reset(input int low);
    bit bad;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (low) @(negedge clock);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    check("rst_start", 64'(conv_start), 64'd0);
    check("rst_conv_bin", 64'(conv_bin), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    reset_n = 1'b1;
    ptr_m = 0;
    cache_v = 1'b0;
    bad = 1'b0;
    repeat (C) begin
      @(negedge clock);
      if (busy !== 1'b1 || ack !== '0 || conv_start !== 1'b0) bad = 1'b1;
    end
    check("flush_hold", 64'(bad), 64'd0);
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit got, bad;
    logic [N-1:0] mask;
    logic [15:0] op, last_op;

    tbl[0] = '{3, 16'd42,    20'h00042};
    tbl[1] = '{1, 16'd4095,  20'h04095};
    tbl[2] = '{2, 16'd4095,  20'h04095};
    tbl[3] = '{0, 16'd777,   20'h00777};
    tbl[4] = '{3, 16'd10000, 20'h10000};

    // Request already pending when reset releases
    bin_bus[0 +: 16] = 16'd12345;
    req[0] = 1'b1;
    do_reset(3);
    serve(4'b0001, cyc);
    check("first_bcd", 64'(bcd_out), 64'h12345);

    for (int i = 0; i < 5; i++) begin
      bin_bus[16*tbl[i].idx +: 16] = tbl[i].op;
      req[tbl[i].idx] = 1'b1;
      mask = '0;
      mask[tbl[i].idx] = 1'b1;
      serve(mask, cyc);
      check("tbl_bcd", 64'(bcd_out), 64'(tbl[i].exp));
    end

    // All four at once, pointer at 0
    bin_bus = {16'd500, 16'd65535, 16'd9, 16'd0};
    req = 4'b1111;
    serve(4'b1111, cyc);
    check("multi_last_bcd", 64'(bcd_out), 64'h00500);

    // Move pointer to 2, then contend 1 vs 3
    bin_bus[16 +: 16] = 16'd1;
    req[1] = 1'b1;
    serve(4'b0010, cyc);
    bin_bus[16 +: 16] = 16'd77;
    bin_bus[48 +: 16] = 16'd88;
    req = 4'b1010;
    serve(4'b1010, cyc);

    // req[2] dropped after grant; req[3] comes and goes while busy; req[0] waits
    bin_bus[32 +: 16] = 16'd2024;
    req[2] = 1'b1;
    r = cyc;
    @(negedge clock);
    check("drop_start", 64'(conv_start), 64'd1);
    req[2] = 1'b0;
    bin_bus[48 +: 16] = 16'd5;
    req[3] = 1'b1;
    bin_bus[0 +: 16] = 16'd8;
    req[0] = 1'b1;
    repeat (3) @(negedge clock);
    req[3] = 1'b0;
    got = 1'b0;
    while (!got && cyc <= r + C + 6) begin
      @(negedge clock);
      if (ack != '0) begin
        got = 1'b1;
        check("drop_ack_idx", 64'(ack), 64'b0100);
        check("drop_ack_cycle", 64'(cyc), 64'(r + C + 2));
        check("drop_bcd", 64'(bcd_out), 64'h02024);
      end
    end
    if (!got) check("drop_ack_timeout", 64'd0, 64'd1);
    ptr_m = 3;
    if (USE_CACHE) begin
      cache_v = 1'b1;
      cache_op = 16'd2024;
    end
    serve(4'b0001, cyc + 1);

    last_op = 16'd8;
    for (int it = 0; it < 8; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int j = 0; j < N; j++) begin
        if (mask[j]) begin
          op = ($urandom_range(0, 2) == 0) ? last_op : 16'($urandom);
          bin_bus[16*j +: 16] = op;
          last_op = op;
        end
      end
      req = mask;
      serve(mask, cyc);
    end

    // Reset in the middle of a conversion
    bin_bus[16 +: 16] = 16'd31415;
    req[1] = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (ack != '0) bad = 1'b1;
    end
    check("abort_no_ack_before", 64'(bad), 64'd0);
    do_reset(2);
    serve(4'b0010, cyc);
    check("post_reset_bcd", 64'(bcd_out), 64'h31415);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin controller that shares one multi-cycle binary-to-BCD converter (16-bit in, 20-bit / 5-digit BCD out, single-cycle `start` strobe, no done flag, no reset) between `N_REQ` requesters such as display channels and register monitors. It sequences the converter and times each conversion with a fixed cycle budget. It returns each result to the winning requester with a one-cycle acknowledge. It sits between the requesters and the converter instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `CONV_CYCLES`, default 184: cycles from the converter start edge until its BCD output is final and it is ready for a new start. Must be ≥ 183.
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  request per requester; held high until `ack`
- `bin_bus`  in  16*N_REQ  operand of requester i at bits [16*i +: 16]; stable while `req[i]` is high
- `ack`  out  N_REQ  one-cycle pulse to the served requester
- `bcd_out`  out  20  result; valid when `ack` is high, held until the next `ack`
- `busy`  out  1  high in any state other than S_IDLE
- `conv_start`  out  1  start strobe to the converter
- `conv_bin`  out  16  operand to the converter
- `conv_bcd`  in  20  converter result

## Operation
- States:
  - S_FLUSH: entered on reset. Counts `CONV_CYCLES`, because the converter has no reset and may be mid-conversion. Then goes to S_IDLE.
  - S_IDLE: if any `req` is high, picks the winner and latches its operand and index. Then goes to S_START, or to S_DONE on a cache hit. Otherwise stays in S_IDLE.
  - S_START: `conv_start`=1 for exactly this cycle; `conv_bin` = latched operand. Goes to S_WAIT.
  - S_WAIT: counts down `CONV_CYCLES`-1 cycles; `conv_bin` stays held. Goes to S_DONE.
  - S_DONE: registers `conv_bcd` (or the cached value) into `bcd_out`, pulses `ack[winner]`, advances the pointer. Goes to S_IDLE.
- Arbitration:
  - Round-robin. The pointer starts at 0.
  - The search starts at the requester after the last served one.
  - Only the grant instant counts; later `req` changes do not pre-empt.
- A `req` dropped after grant still receives `ack` and the result.
- A `req` dropped before grant is never served.
- A requester still high in the cycle after its `ack` is treated as a new request.
- Reset values: `ack`=0, `bcd_out`=0, `conv_start`=0, `conv_bin`=0, `busy`=1, pointer=0, state=S_FLUSH.
- Reset asserted mid-conversion aborts the conversion with no `ack` and re-enters S_FLUSH.
- The operand is 16-bit unsigned. The result covers 0..65535, with digit 4 at bits [19:16].
- The wait counter is 8 bits; `CONV_CYCLES` ≤ 255.

## Timing
- R = first S_IDLE cycle in which `req` is high.
  - `conv_start` is high in cycle R+1.
  - `ack` and `bcd_out` are valid in cycle R+CONV_CYCLES+2.
  - `busy` rises in cycle R+1.
  - `busy` falls in cycle R+CONV_CYCLES+3, when the state is S_IDLE again.
- Back-to-back requests: at most one start every CONV_CYCLES+3 cycles.
- After reset release, the first start occurs no earlier than CONV_CYCLES+2 cycles later.
- `ack` is never high for more than one requester or for more than one cycle.

## Configuration
- `BCD_CACHE_EN` defined:
  - Keeps one entry holding the last converted operand and its BCD.
  - The entry is invalidated by reset.
  - A winning operand equal to the valid entry skips S_START and S_WAIT. `ack` then comes in cycle R+1, with `conv_start` never asserted.
  - A miss refreshes the entry in S_DONE.
- `BCD_CACHE_EN` undefined: every grant runs the converter; there is no cache storage.

## Structure
- Package `bcd_ctrl_pkg`:
  - state enum
  - `BIN_W`=16, `BCD_W`=20, `BCD_DIGITS`=5
  - `CONV_CYCLES_MIN`=183
- Sub-module `rr_pick`: combinational round-robin picker taking `req` and pointer, returning a one-hot grant and an index.

## Test plan
- Reset release with `req[0]`=1 and operand 12345 → `conv_start` in cycle CONV_CYCLES+2, then `ack[0]` with `bcd_out`=20'h12345.
- All four requesters high, operands 0, 9, 65535, 500 → acks arrive in order 0, 1, 2, 3 with 20'h00000, 20'h00009, 20'h65535, 20'h00500, spaced CONV_CYCLES+3 apart.
- Pointer at 2 with `req[1]` and `req[3]` high → `req[3]` is served first.
- `reset_n` pulsed low mid-S_WAIT → no `ack`; `busy` stays high through S_FLUSH; the next conversion still returns the correct value.
- `req[2]` dropped one cycle after grant → `ack[2]` still pulses with the correct BCD; no other requester is served in that slot.
- Cache build: operand 4095 twice from different requesters → second `ack` in cycle R+1 with 20'h04095 and no `conv_start`. A different value after that → full conversion.
